// File: rtl/branch_history_ctrl_if.sv
// Lookup/update/prediction bundle between the fetch/execute pipeline and the PHT controller.
interface branch_history_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             lookup_valid;
  logic             lookup_hold;
  logic [31:0]      lookup_pc;
  logic [1:0]       pred_counter;
  logic             pred_ready;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             upd_pred_taken;
  logic             mispredict;
  logic [CNT_W-1:0] perf_branches;
  logic [CNT_W-1:0] perf_mispredicts;

  // Pipeline side: issues lookups and resolved branches
  modport master (
    output lookup_valid, lookup_hold, lookup_pc,
    output upd_valid, upd_pc, upd_taken, upd_pred_taken,
    input  pred_counter, pred_ready, mispredict,
    input  perf_branches, perf_mispredicts
  );

  // Predictor side: owns the table
  modport slave (
    input  lookup_valid, lookup_hold, lookup_pc,
    input  upd_valid, upd_pc, upd_taken, upd_pred_taken,
    output pred_counter, pred_ready, mispredict,
    output perf_branches, perf_mispredicts
  );
endinterface

// File: rtl/branch_history_ctrl.sv
// 2-bit saturating pattern-history table with init sweep, lookup bypass and
// registered mispredict pulse. Optional performance counters: BP_PERF_CNT_EN.
module branch_history_ctrl #(
  parameter int unsigned IDX_W    = 6,
  parameter logic [1:0]  INIT_VAL = 2'b01,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_history_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_idx, init_idx_nxt;
  logic [1:0]       pht [DEPTH];

  logic [IDX_W-1:0] lk_idx_c, upd_idx_c;
  logic [1:0]       upd_cur_c, upd_new_c;
  logic             upd_fire_c, lk_fire_c, bypass_c;
  logic             unused_pc_bits;

  assign lk_idx_c  = bus.lookup_pc[IDX_W+1:2];
  assign upd_idx_c = bus.upd_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0],
                            bus.upd_pc[31:IDX_W+2], bus.upd_pc[1:0]};

  // State register and sweep index
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nxt;
      init_idx <= init_idx_nxt;
    end
  end

  // Next-state: sweep every entry once, then stay in RUN
  always_comb begin
    state_nxt    = state;
    init_idx_nxt = init_idx;
    case (state)
      ST_INIT: begin
        init_idx_nxt = init_idx + IDX_W'(1);
        if (init_idx == IDX_W'(DEPTH - 1)) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt    = ST_INIT;
        init_idx_nxt = '0;
      end
    endcase
  end

  // Saturating update value and lookup/update decode
  always_comb begin
    upd_fire_c = (state == ST_RUN) && bus.upd_valid;
    lk_fire_c  = bus.lookup_valid && !bus.lookup_hold;
    upd_cur_c  = pht[upd_idx_c];
    upd_new_c  = upd_cur_c;
    if (bus.upd_taken) begin
      if (upd_cur_c != 2'b11) upd_new_c = upd_cur_c + 2'(1);
    end else begin
      if (upd_cur_c != 2'b00) upd_new_c = upd_cur_c - 2'(1);
    end
    bypass_c = upd_fire_c && (upd_idx_c == lk_idx_c);
  end

  // Table writes: sweep in INIT, counter update in RUN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        pht[init_idx] <= INIT_VAL;
      end else if (upd_fire_c) begin
        pht[upd_idx_c] <= upd_new_c;
      end
    end
  end

  // Registered prediction, ready flag and mispredict pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pred_counter <= 2'b00;
      bus.pred_ready   <= 1'b0;
      bus.mispredict   <= 1'b0;
    end else begin
      bus.pred_ready <= (state_nxt == ST_RUN);
      bus.mispredict <= upd_fire_c && (bus.upd_taken != bus.upd_pred_taken);
      if (state == ST_INIT) begin
        bus.pred_counter <= 2'b00;
      end else if (lk_fire_c) begin
        bus.pred_counter <= bypass_c ? upd_new_c : pht[lk_idx_c];
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [CNT_W-1:0] br_cnt, mp_cnt;

  // Saturating resolved-branch and mispredict counters
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (upd_fire_c) begin
      if (!(&br_cnt)) br_cnt <= br_cnt + CNT_W'(1);
      if ((bus.upd_taken != bus.upd_pred_taken) && !(&mp_cnt)) begin
        mp_cnt <= mp_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.perf_branches    = br_cnt;
  assign bus.perf_mispredicts = mp_cnt;
`else
  assign bus.perf_branches    = '0;
  assign bus.perf_mispredicts = '0;
`endif

endmodule
